// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster pixel stream to vertical WINDOW_SIZE column windows via line buffers.
// Optional top zero padding when WINDOW_ZERO_PAD_EN is defined.
module cnn_window_gen #(
  parameter int WINDOW_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pix_valid,
  input  logic [31:0]                  pix_data,
  output logic                         pix_ready,
  output logic                         window_valid,
  output logic [WINDOW_SIZE-1:0][31:0] window,
  input  logic                         window_stall,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0] lb_q [WINDOW_SIZE-1][IMG_WIDTH];
  logic [WINDOW_SIZE-1:0][31:0] win_d, window_q;
  logic valid_q, valid_d, accept, last_col, last_pix;
  assign pix_ready    = state_q == RUN && !window_stall;
  assign accept       = pix_valid && pix_ready;
  assign busy         = state_q != IDLE;
  assign frame_done   = state_q == DRAIN && !window_stall;
  assign window       = window_q;
  assign window_valid = valid_q;
  assign last_col     = col_q == CW'(IMG_WIDTH - 1);
  assign last_pix     = last_col && row_q == RW'(IMG_HEIGHT - 1);
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      col_d   = '0;
      row_d   = '0;
    end else if (accept) begin
      col_d   = last_col ? '0 : col_q + 1'b1;
      row_d   = last_pix ? '0 : last_col ? row_q + 1'b1 : row_q;
      state_d = last_pix ? DRAIN : RUN;
    end else if (frame_done) begin
      state_d = IDLE;
    end
  end
  // Column for the current pixel: older rows from the line buffers, newest row from the input.
  always_comb begin
    for (int k = 0; k < WINDOW_SIZE - 1; k++) win_d[k] = lb_q[k][col_q];
    win_d[WINDOW_SIZE-1] = pix_data;
`ifdef WINDOW_ZERO_PAD_EN
    for (int k = 0; k < WINDOW_SIZE - 1; k++) win_d[k] = int'(row_q) + k < WINDOW_SIZE - 1 ? '0 : win_d[k];
    valid_d = 1'b1;
`else
    valid_d = row_q >= RW'(WINDOW_SIZE - 1);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (!window_stall) valid_q <= accept && valid_d;
      if (accept) window_q <= win_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < WINDOW_SIZE - 2; k++) lb_q[k][col_q] <= lb_q[k+1][col_q];
      lb_q[WINDOW_SIZE-2][col_q] <= pix_data;
    end
  end
endmodule
